// File: rtl/seq_ctrl_if.sv
// Sequencer-to-datapath bundle: start/step request plus address and strobe outputs.
// With SEQ_CTRL_STEP_EN defined the bundle carries an extra step input.
interface seq_ctrl_if #(
  parameter int AW = 6
);
  logic          start;
`ifdef SEQ_CTRL_STEP_EN
  logic          step;
`endif
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [AW-1:0] waddr;
  logic          rf_we;
  logic          ram_we;
  logic          sel_ram;
  logic          busy;
  logic          done;

`ifdef SEQ_CTRL_STEP_EN
  modport master (
    input  start, step,
    output raddr1, raddr2, waddr, rf_we, ram_we, sel_ram, busy, done
  );
  modport slave (
    output start, step,
    input  raddr1, raddr2, waddr, rf_we, ram_we, sel_ram, busy, done
  );
`else
  modport master (
    input  start,
    output raddr1, raddr2, waddr, rf_we, ram_we, sel_ram, busy, done
  );
  modport slave (
    output start,
    input  raddr1, raddr2, waddr, rf_we, ram_we, sel_ram, busy, done
  );
`endif
endinterface

// File: rtl/seq_ctrl.sv
// Address/strobe sequencer: preloads INIT_WORDS RAM words into the regfile, then runs
// reg[n] = ALU(reg[n-2], reg[n-1]) up to LAST_ADDR. Optional SEQ_CTRL_STEP_EN adds step gating.
module seq_ctrl #(
  parameter int AW         = 6,
  parameter int INIT_WORDS = 3,
  parameter int LAST_ADDR  = 61
) (
  input  logic       clk,
  input  logic       rst,
  seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  localparam logic [AW:0] INIT_C = (AW+1)'(INIT_WORDS);
  localparam logic [AW:0] LAST_C = (AW+1)'(LAST_ADDR);
  localparam logic [AW:0] ONE_C  = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] cnt_a;
  logic [AW-1:0] raddr1_q, raddr1_d;
  logic [AW-1:0] raddr2_q, raddr2_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          rf_we_q, rf_we_d;
  logic          ram_we_q, ram_we_d;
  logic          sel_ram_q, sel_ram_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          adv;

`ifdef SEQ_CTRL_STEP_EN
  assign adv = bus.step;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (adv) begin
          if (cnt_q == INIT_C) begin
            state_d = CALC;
            cnt_d   = INIT_C;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
      end
      CALC: begin
        if (adv) begin
          if (cnt_q == LAST_C) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copy lines up with the state.
  always_comb begin
    cnt_a     = cnt_d[AW-1:0];
    raddr1_d  = '0;
    raddr2_d  = '0;
    waddr_d   = '0;
    rf_we_d   = 1'b0;
    ram_we_d  = 1'b0;
    sel_ram_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      LOAD: begin
        raddr1_d  = cnt_a;
        waddr_d   = cnt_a - AW'(1);
        rf_we_d   = (cnt_d != '0);
        sel_ram_d = 1'b1;
        busy_d    = 1'b1;
      end
      CALC: begin
        raddr1_d = cnt_a - AW'(2);
        raddr2_d = cnt_a - AW'(1);
        waddr_d  = cnt_a;
        rf_we_d  = 1'b1;
        ram_we_d = 1'b1;
        busy_d   = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      waddr_q   <= '0;
      rf_we_q   <= 1'b0;
      ram_we_q  <= 1'b0;
      sel_ram_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      raddr1_q  <= raddr1_d;
      raddr2_q  <= raddr2_d;
      waddr_q   <= waddr_d;
      rf_we_q   <= rf_we_d;
      ram_we_q  <= ram_we_d;
      sel_ram_q <= sel_ram_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // A stalled step cycle must not commit a write, so the enables see the live step level.
  assign bus.raddr1  = raddr1_q;
  assign bus.raddr2  = raddr2_q;
  assign bus.waddr   = waddr_q;
  assign bus.rf_we   = rf_we_q & adv;
  assign bus.ram_we  = ram_we_q & adv;
  assign bus.sel_ram = sel_ram_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: two instances (default and short parameters) checked
// cycle by cycle against a run-index reference model. Step tests need SEQ_CTRL_STEP_EN.
module tb_seq_ctrl;

  typedef struct packed {
    logic [5:0] raddr1;
    logic [5:0] raddr2;
    logic [5:0] waddr;
    logic       rf_we;
    logic       ram_we;
    logic       sel_ram;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  logic step_v;
  int   checks;
  int   errors;

  // Model state per instance: mode 0=idle, 1=running, 2=done; k = cycles into the run.
  int mode_a, k_a, mode_b, k_b;

  seq_ctrl_if #(.AW(6)) bus_a ();
  seq_ctrl_if #(.AW(6)) bus_b ();

`ifdef SEQ_CTRL_STEP_EN
  assign bus_a.step = step_v;
  assign bus_b.step = step_v;
`endif

  seq_ctrl #(.AW(6), .INIT_WORDS(3), .LAST_ADDR(61)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seq_ctrl #(.AW(6), .INIT_WORDS(2), .LAST_ADDR(5)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  exp_t obs_a, obs_b;
  assign obs_a = {bus_a.raddr1, bus_a.raddr2, bus_a.waddr, bus_a.rf_we,
                  bus_a.ram_we, bus_a.sel_ram, bus_a.busy, bus_a.done};
  assign obs_b = {bus_b.raddr1, bus_b.raddr2, bus_b.waddr, bus_b.rf_we,
                  bus_b.ram_we, bus_b.sel_ram, bus_b.busy, bus_b.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs from the run index: k <= iw is preload word k, then compute n = k-1.
  function automatic exp_t expect_out(int mode, int k, int iw, logic sp);
    exp_t e;
    int   n;
    e = '0;
    if (mode == 1) begin
      e.busy = 1'b1;
      if (k <= iw) begin
        e.raddr1  = 6'(k);
        e.waddr   = 6'(k - 1);
        e.rf_we   = (k != 0) && sp;
        e.sel_ram = 1'b1;
      end else begin
        n        = k - 1;
        e.raddr1 = 6'(n - 2);
        e.raddr2 = 6'(n - 1);
        e.waddr  = 6'(n);
        e.rf_we  = sp;
        e.ram_we = sp;
      end
    end else if (mode == 2) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t mask_for(int mode, int k);
    exp_t m;
    m = '1;
    if (mode == 1 && k == 0) m.waddr = '0;
    return m;
  endfunction

  task automatic model_step(inout int mode, inout int k, input logic st, input logic sp,
                            input int la);
    if (mode == 0) begin
      if (st) begin
        mode = 1;
        k    = 0;
      end
    end else if (mode == 1) begin
      if (sp) begin
        if (k == la + 1) mode = 2;
        else k = k + 1;
      end
    end else begin
      mode = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_step(mode_a, k_a, bus_a.start, step_v, 61);
      model_step(mode_b, k_b, bus_b.start, step_v, 5);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    step_v = 1'b1;
    mode_a = 0; k_a = 0; mode_b = 0; k_b = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obs_a !== 23'h0 || obs_b !== 23'h0) begin
        errors++;
        $display("[TB] FAIL reset_hold got a=%h b=%h exp=0", obs_a, obs_b);
      end
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (obs_a !== 23'h0 || obs_b !== 23'h0) begin
        errors++;
        $display("[TB] FAIL reset_idle got a=%h b=%h exp=0", obs_a, obs_b);
      end
    end
  endtask

  task automatic test_load_calc();
    int busy_cnt, done_cnt;
    bit finished;
    exp_t e, m;
    busy_cnt = 0; done_cnt = 0; finished = 0;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int c = 0; c < 100 && !finished; c++) begin
      #1;
      e = expect_out(mode_a, k_a, 3, step_v);
      m = mask_for(mode_a, k_a);
      checks++;
      if ((obs_a & m) !== (e & m)) begin
        errors++;
        $display("[TB] FAIL load_calc cyc=%0d got=%h exp=%h", c, obs_a, e);
      end
      if (mode_a == 1 && k_a == 4) begin
        checks++;
        if (bus_a.raddr1 !== 6'd1 || bus_a.raddr2 !== 6'd2 || bus_a.waddr !== 6'd3 ||
            bus_a.sel_ram !== 1'b0 || bus_a.ram_we !== 1'b1) begin
          errors++;
          $display("[TB] FAIL first_calc got r1=%0d r2=%0d w=%0d exp 1 2 3", bus_a.raddr1,
                   bus_a.raddr2, bus_a.waddr);
        end
      end
      if (mode_a == 1 && k_a == 62) begin
        checks++;
        if (bus_a.raddr1 !== 6'd59 || bus_a.raddr2 !== 6'd60 || bus_a.waddr !== 6'd61) begin
          errors++;
          $display("[TB] FAIL last_calc got r1=%0d r2=%0d w=%0d exp 59 60 61", bus_a.raddr1,
                   bus_a.raddr2, bus_a.waddr);
        end
      end
      if (bus_a.busy === 1'b1) busy_cnt++;
      if (bus_a.done === 1'b1) done_cnt++;
      if (mode_a == 0 && c > 0) finished = 1;
      else tick();
    end
    checks++;
    if (!finished || busy_cnt != 63 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL run_length got busy=%0d done=%0d finished=%0d exp busy=63 done=1",
               busy_cnt, done_cnt, finished);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit reached;
    reached = 0;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      if (mode_a == 1 && k_a == 21) reached = 1;
      else tick();
    end
    #1;
    checks++;
    if (!reached || bus_a.waddr !== 6'd20) begin
      errors++;
      $display("[TB] FAIL mid_calc_reach got waddr=%0d exp 20", bus_a.waddr);
    end
    @(negedge clk);
    rst = 1'b1;
    mode_a = 0; mode_b = 0;
    #1;
    checks++;
    if (obs_a !== 23'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_immediate got=%h exp=0", obs_a);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (obs_a !== 23'h0) begin
        errors++;
        $display("[TB] FAIL mid_reset_idle got=%h exp=0", obs_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen_done, restarted, finished;
    int done_cyc, load_cyc;
    exp_t e, m;
    seen_done = 0; restarted = 0; finished = 0; done_cyc = -1; load_cyc = -1;
    bus_a.start = 1'b1;
    tick();
    for (int c = 0; c < 300 && !finished; c++) begin
      bus_a.start = !restarted &&
                    ((mode_a == 1 && (k_a == 11 || k_a >= 61)) || mode_a == 2 || seen_done);
      #1;
      e = expect_out(mode_a, k_a, 3, step_v);
      m = mask_for(mode_a, k_a);
      checks++;
      if ((obs_a & m) !== (e & m)) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs_a, e);
      end
      if (mode_a == 2 && !seen_done) begin
        seen_done = 1;
        done_cyc = c;
      end
      if (seen_done && !restarted && bus_a.busy === 1'b1) begin
        restarted = 1;
        load_cyc = c;
      end
      if (restarted && mode_a == 0) finished = 1;
      else tick();
    end
    bus_a.start = 1'b0;
    checks++;
    if (!finished || load_cyc != done_cyc + 2) begin
      errors++;
      $display("[TB] FAIL restart_timing got done=%0d load=%0d finished=%0d exp load=done+2",
               done_cyc, load_cyc, finished);
    end
  endtask

  task automatic test_short_params();
    int busy_cnt, done_cnt, w6;
    bit finished;
    exp_t e, m;
    busy_cnt = 0; done_cnt = 0; w6 = 0; finished = 0;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      #1;
      e = expect_out(mode_b, k_b, 2, step_v);
      m = mask_for(mode_b, k_b);
      checks++;
      if ((obs_b & m) !== (e & m)) begin
        errors++;
        $display("[TB] FAIL short_run cyc=%0d got=%h exp=%h", c, obs_b, e);
      end
      if (bus_b.busy === 1'b1) busy_cnt++;
      if (bus_b.done === 1'b1) done_cnt++;
      if ((bus_b.ram_we === 1'b1 || bus_b.rf_we === 1'b1) && bus_b.waddr === 6'd6) w6++;
      if (mode_b == 0 && c > 0) finished = 1;
      else tick();
    end
    checks++;
    if (!finished || busy_cnt != 7 || done_cnt != 1 || w6 != 0) begin
      errors++;
      $display("[TB] FAIL short_summary got busy=%0d done=%0d w6=%0d exp busy=7 done=1 w6=0",
               busy_cnt, done_cnt, w6);
    end
  endtask

`ifdef SEQ_CTRL_STEP_EN
  task automatic test_step();
    logic [5:0] exp_w [5];
    logic       pat   [5];
    bit         reached;
    exp_w = '{6'd7, 6'd8, 6'd8, 6'd8, 6'd9};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    reached = 0;
    step_v = 1'b1;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      if (mode_a == 1 && k_a == 8) reached = 1;
      else tick();
    end
    for (int i = 0; i < 5; i++) begin
      step_v = pat[i];
      #1;
      checks++;
      if (!reached || bus_a.waddr !== exp_w[i] || bus_a.ram_we !== pat[i]) begin
        errors++;
        $display("[TB] FAIL step_seq i=%0d got w=%0d we=%b exp w=%0d we=%b", i, bus_a.waddr,
                 bus_a.ram_we, exp_w[i], pat[i]);
      end
      tick();
    end
    step_v = 1'b1;
    for (int c = 0; c < 100 && mode_a != 0; c++) tick();
  endtask
`endif

  task automatic test_random();
    exp_t e, m;
    for (int c = 0; c < 1500; c++) begin
      bus_a.start = ($urandom_range(0, 3) == 0);
      bus_b.start = ($urandom_range(0, 2) == 0);
`ifdef SEQ_CTRL_STEP_EN
      step_v = ($urandom_range(0, 2) != 0);
`endif
      #1;
      e = expect_out(mode_a, k_a, 3, step_v);
      m = mask_for(mode_a, k_a);
      checks++;
      if ((obs_a & m) !== (e & m)) begin
        errors++;
        $display("[TB] FAIL random_a cyc=%0d got=%h exp=%h", c, obs_a, e);
      end
      e = expect_out(mode_b, k_b, 2, step_v);
      m = mask_for(mode_b, k_b);
      checks++;
      if ((obs_b & m) !== (e & m)) begin
        errors++;
        $display("[TB] FAIL random_b cyc=%0d got=%h exp=%h", c, obs_b, e);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    step_v = 1'b1;
    test_reset();
    test_load_calc();
    test_reset_mid_calc();
    test_back_to_back();
    test_short_params();
`ifdef SEQ_CTRL_STEP_EN
    test_step();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
